switch_mc: RTL and testbench

SWITCH_MC -- requirements
Module: switch_mc

---
 rtl/switch_mc_if.sv | 34 +++
 rtl/switch_mc.sv | 105 ++++++++++
 tb/tb_switch_mc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/switch_mc_if.sv
// Handshake and bus bundle for switch_mc: table write port, packet offer, per-port outputs.
interface switch_mc_if #(
  parameter int unsigned NUM_OF_PORTS     = 4,
  parameter int unsigned PORT_ADDR_LENGTH = 4,
  parameter int unsigned DATA_WIDTH       = 8
);
  localparam int unsigned IdxW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;

  logic [IdxW-1:0]                     mem_port_index;
  logic [PORT_ADDR_LENGTH-1:0]         port_address;
  logic                                mem_write;
  logic [PORT_ADDR_LENGTH-1:0]         packet_addr;
  logic [DATA_WIDTH-1:0]               packet_data;
  logic                                packet_send_req;
  logic                                packet_ready;
  logic                                packet_finished;
  logic                                packet_dropped;
  logic [15:0]                         drop_count;
  logic [NUM_OF_PORTS-1:0]             port_req;
  logic [NUM_OF_PORTS*DATA_WIDTH-1:0]  port_data;
  logic [NUM_OF_PORTS-1:0]             port_received;

  modport master (
    output mem_port_index, port_address, mem_write,
    output packet_addr, packet_data, packet_send_req, port_received,
    input  packet_ready, packet_finished, packet_dropped, drop_count, port_req, port_data
  );

  modport slave (
    input  mem_port_index, port_address, mem_write,
    input  packet_addr, packet_data, packet_send_req, port_received,
    output packet_ready, packet_finished, packet_dropped, drop_count, port_req, port_data
  );
endinterface

// File: rtl/switch_mc.sv
// Multicast switch: address-table lookup fans each accepted word into every matching
// output FIFO atomically; unmatched words are dropped and counted.
module switch_mc #(
  parameter int unsigned NUM_OF_PORTS     = 4,
  parameter int unsigned PORT_ADDR_LENGTH = 4,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input logic        clk,
  input logic        reset,
  switch_mc_if.slave bus
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PORT_ADDR_LENGTH-1:0] table_q [NUM_OF_PORTS];
  logic [DATA_WIDTH-1:0]       mem_q   [NUM_OF_PORTS][FIFO_DEPTH];
  logic [PtrW-1:0]             rd_ptr_q[NUM_OF_PORTS];
  logic [PtrW-1:0]             wr_ptr_q[NUM_OF_PORTS];
  logic [CntW-1:0]             count_q [NUM_OF_PORTS];

  logic [NUM_OF_PORTS-1:0] mask, full, empty, push, pop;
  logic                    accept;
  logic                    finished_q, dropped_q;
  logic [15:0]             drop_count_q;

  always_comb begin
    mask  = '0;
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      mask[i]  = (bus.packet_addr == '1) || (table_q[i] == bus.packet_addr);
      full[i]  = (count_q[i] == CntW'(FIFO_DEPTH));
      empty[i] = (count_q[i] == '0);
    end
  end

  // Ready ignores pops in the same cycle, so a full targeted FIFO always blocks.
  assign bus.packet_ready = ~|(mask & full);
  assign accept           = bus.packet_send_req & bus.packet_ready;
  assign push             = mask & {NUM_OF_PORTS{accept}};
  assign pop              = bus.port_received & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
        table_q[i] <= PORT_ADDR_LENGTH'(i);
      end
    end else if (bus.mem_write) begin
      table_q[bus.mem_port_index] <= bus.port_address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + CntW'(1);
          2'b01:   count_q[i] <= count_q[i] - CntW'(1);
          default: count_q[i] <= count_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.packet_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finished_q   <= 1'b0;
      dropped_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      finished_q <= accept & (|mask);
      dropped_q  <= accept & ~(|mask);
      if (accept && !(|mask) && drop_count_q != 16'hFFFF) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    bus.port_data = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      bus.port_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign bus.port_req        = ~empty;
  assign bus.packet_finished = finished_q;
  assign bus.packet_dropped  = dropped_q;
  assign bus.drop_count      = drop_count_q;
endmodule

// File: tb/tb_switch_mc.sv
// Directed bench for switch_mc: unicast, multicast, backpressure, drop, broadcast, reset.
module tb_switch_mc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  switch_mc_if #(.NUM_OF_PORTS(4), .PORT_ADDR_LENGTH(4), .DATA_WIDTH(8)) bus ();

  switch_mc #(
    .NUM_OF_PORTS(4), .PORT_ADDR_LENGTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] addr, input logic [7:0] data);
    bus.packet_addr     = addr;
    bus.packet_data     = data;
    bus.packet_send_req = 1'b1;
    tick();
    bus.packet_send_req = 1'b0;
  endtask

  task automatic pop(input logic [3:0] ports);
    bus.port_received = ports;
    tick();
    bus.port_received = '0;
  endtask

  initial begin
    bus.mem_port_index  = '0;
    bus.port_address    = '0;
    bus.mem_write       = 1'b0;
    bus.packet_addr     = '0;
    bus.packet_data     = '0;
    bus.packet_send_req = 1'b0;
    bus.port_received   = '0;

    // Reset state
    tick();
    chk("rst_port_req", bus.port_req, 4'b0000);
    chk("rst_finished", bus.packet_finished, 1'b0);
    chk("rst_dropped", bus.packet_dropped, 1'b0);
    chk("rst_drop_count", bus.drop_count, 16'd0);
    reset = 1'b0;
    tick();

    // Unicast to port 2
    bus.packet_addr     = 4'd2;
    bus.packet_data     = 8'hA5;
    bus.packet_send_req = 1'b1;
    #1;
    chk("uni_ready", bus.packet_ready, 1'b1);
    tick();
    bus.packet_send_req = 1'b0;
    chk("uni_port_req", bus.port_req, 4'b0100);
    chk("uni_data2", bus.port_data[23:16], 8'hA5);
    chk("uni_finished", bus.packet_finished, 1'b1);
    chk("uni_dropped", bus.packet_dropped, 1'b0);
    pop(4'b0100);
    chk("uni_finished_pulse", bus.packet_finished, 1'b0);
    chk("uni_pop", bus.port_req, 4'b0000);

    // Multicast: entries 1 and 3 both take address 5
    bus.mem_write = 1'b1;
    bus.mem_port_index = 2'd1;
    bus.port_address   = 4'd5;
    tick();
    bus.mem_port_index = 2'd3;
    tick();
    bus.mem_write = 1'b0;
    send(4'd5, 8'h3C);
    chk("mc_port_req", bus.port_req, 4'b1010);
    chk("mc_data1", bus.port_data[15:8], 8'h3C);
    chk("mc_data3", bus.port_data[31:24], 8'h3C);
    chk("mc_finished", bus.packet_finished, 1'b1);
    pop(4'b0010);
    chk("mc_pop1", bus.port_req, 4'b1000);
    pop(4'b1000);
    chk("mc_pop3", bus.port_req, 4'b0000);

    // Backpressure on port 0, then order across pointer wrap
    send(4'd0, 8'h11);
    send(4'd0, 8'h22);
    send(4'd0, 8'h33);
    send(4'd0, 8'h44);
    bus.packet_addr     = 4'd0;
    bus.packet_data     = 8'h55;
    bus.packet_send_req = 1'b1;
    #1;
    chk("bp_ready_full", bus.packet_ready, 1'b0);
    tick();
    chk("bp_blocked_req", bus.port_req, 4'b0001);
    chk("bp_blocked_head", bus.port_data[7:0], 8'h11);
    chk("bp_blocked_fin", bus.packet_finished, 1'b0);
    pop(4'b0001);
    chk("bp_ready_after_pop", bus.packet_ready, 1'b1);
    chk("bp_head_22", bus.port_data[7:0], 8'h22);
    tick();
    bus.packet_send_req = 1'b0;
    chk("bp_accept_fin", bus.packet_finished, 1'b1);
    chk("bp_order_22", bus.port_data[7:0], 8'h22);
    pop(4'b0001);
    chk("bp_order_33", bus.port_data[7:0], 8'h33);
    pop(4'b0001);
    chk("bp_order_44", bus.port_data[7:0], 8'h44);
    pop(4'b0001);
    chk("bp_order_55", bus.port_data[7:0], 8'h55);
    pop(4'b0001);
    chk("bp_empty", bus.port_req, 4'b0000);

    // Drop: address 9 matches no entry
    send(4'd9, 8'h77);
    chk("drop_pulse", bus.packet_dropped, 1'b1);
    chk("drop_no_fin", bus.packet_finished, 1'b0);
    chk("drop_count1", bus.drop_count, 16'd1);
    chk("drop_port_req", bus.port_req, 4'b0000);
    tick();
    chk("drop_pulse_end", bus.packet_dropped, 1'b0);

    // Broadcast with port 0 full and a simultaneous pop on port 0
    send(4'd0, 8'hA0);
    send(4'd0, 8'hA1);
    send(4'd0, 8'hA2);
    send(4'd0, 8'hA3);
    bus.packet_addr     = 4'hF;
    bus.packet_data     = 8'hEE;
    bus.packet_send_req = 1'b1;
    bus.port_received   = 4'b0001;
    #1;
    chk("bc_ready", bus.packet_ready, 1'b0);
    tick();
    bus.packet_send_req = 1'b0;
    bus.port_received   = '0;
    chk("bc_port_req", bus.port_req, 4'b0001);
    chk("bc_head", bus.port_data[7:0], 8'hA1);
    chk("bc_no_fin", bus.packet_finished, 1'b0);
    chk("bc_no_drop", bus.packet_dropped, 1'b0);
    chk("bc_drop_count", bus.drop_count, 16'd1);

    // Reset mid-traffic
    send(4'd2, 8'hB2);
    chk("rm_pre_req", bus.port_req, 4'b0101);
    reset = 1'b1;
    #1;
    chk("rm_port_req", bus.port_req, 4'b0000);
    chk("rm_drop_count", bus.drop_count, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rm_rel_fin", bus.packet_finished, 1'b0);
    chk("rm_rel_drop", bus.packet_dropped, 1'b0);
    chk("rm_rel_req", bus.port_req, 4'b0000);
    send(4'd1, 8'hC1);
    chk("rm_table1", bus.port_req, 4'b0010);
    chk("rm_data1", bus.port_data[15:8], 8'hC1);
    send(4'd5, 8'hC5);
    chk("rm_table5_drop", bus.packet_dropped, 1'b1);
    chk("rm_drop_count1", bus.drop_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
